crossbar_arbiter: RTL

CROSSBAR_ARBITER -- requirements
Module: crossbar_arbiter

---
 rtl/crossbar_pkg.sv | 17 +
 rtl/crossbar_rr_arb.sv | 59 +++++
 rtl/crossbar_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/crossbar_pkg.sv
// crossbar_pkg
//   Shared definitions for the 2x2 crossbar arbiter.
//   DATA_W_DEFAULT : default payload width.
//   CNT_W / CNT_MAX: width and saturation value of the contention counter.
//   port_idx_t     : input-port index (PORT1 = input 1, PORT2 = input 2).
package crossbar_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int CNT_W          = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef enum logic {
    PORT1 = 1'b0,
    PORT2 = 1'b1
  } port_idx_t;

endpackage

// File: rtl/crossbar_rr_arb.sv
// crossbar_rr_arb
//   Two-requester arbiter for one crossbar output.
//   Optional feature macro: CROSSBAR_ARBITER_RR_EN
//     defined   : a priority pointer alternates the winner on contention.
//     undefined : no pointer, input 1 always wins contention.
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset; forces no grant
//   req[1:0]   : bit 0 = input 1 requests, bit 1 = input 2 requests
//   loadable   : the output slot can take a word this cycle
//   gnt[1:0]   : one-hot grant (bit 0 = input 1, bit 1 = input 2)
//   contention : both inputs request this output
module crossbar_rr_arb
  import crossbar_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       loadable,
  output logic [1:0] gnt,
  output logic       contention
);

  port_idx_t winner;

`ifdef CROSSBAR_ARBITER_RR_EN
  port_idx_t ptr_q;

  // Pointer moves to the loser only when a contended grant actually happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PORT1;
    end else if (loadable && (&req)) begin
      ptr_q <= gnt[0] ? PORT2 : PORT1;
    end
  end

  assign winner = ptr_q;
`else
  logic unused_clk;

  assign unused_clk = clk;
  assign winner     = PORT1;
`endif

  always_comb begin
    gnt = 2'b00;
    if (!rst && loadable) begin
      if (&req) begin
        gnt = (winner == PORT1) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  assign contention = &req;

endmodule

// File: rtl/crossbar_arbiter.sv
// crossbar_arbiter
//   2-input / 2-output crossbar with one-word registered output slots.
//   Optional feature macro: CROSSBAR_ARBITER_RR_EN (round-robin contention
//   pointer per output; when undefined input 1 always wins contention).
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   inX_valid/data/dest      : input word, dest 0 = output 1, 1 = output 2
//   inX_ready                : combinational accept for input X
//   outK_valid/data          : registered output slot
//   outK_ready               : consumer takes the slot word this cycle
//   selK                     : source of last word loaded (0 = in1, 1 = in2)
//   conflict_cnt             : saturating count of contention cycles
module crossbar_arbiter
  import crossbar_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_dest,
  output logic              in1_ready,
  input  logic              in2_valid,
  input  logic [DATA_W-1:0] in2_data,
  input  logic              in2_dest,
  output logic              in2_ready,
  output logic              out1_valid,
  output logic [DATA_W-1:0] out1_data,
  input  logic              out1_ready,
  output logic              out2_valid,
  output logic [DATA_W-1:0] out2_data,
  input  logic              out2_ready,
  output logic              sel1,
  output logic              sel2,
  output logic [CNT_W-1:0]  conflict_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  logic [1:0]        req1, req2;
  logic [1:0]        gnt1, gnt2;
  logic              cont1, cont2;
  logic              loadable1, loadable2;
  logic              vld1_p1, vld2_p1;
  logic [DATA_W-1:0] data1_p1, data2_p1;
  port_idx_t         sel1_p1, sel2_p1;
  logic [CNT_W-1:0]  cnt_p1;

  // Stage 0: request decode and arbitration (combinational)
  assign req1 = {in2_valid && !in2_dest, in1_valid && !in1_dest};
  assign req2 = {in2_valid &&  in2_dest, in1_valid &&  in1_dest};

  assign loadable1 = !vld1_p1 || out1_ready;
  assign loadable2 = !vld2_p1 || out2_ready;

  crossbar_rr_arb u_arb1 (
    .clk        (clk),
    .rst        (rst),
    .req        (req1),
    .loadable   (loadable1),
    .gnt        (gnt1),
    .contention (cont1)
  );

  crossbar_rr_arb u_arb2 (
    .clk        (clk),
    .rst        (rst),
    .req        (req2),
    .loadable   (loadable2),
    .gnt        (gnt2),
    .contention (cont2)
  );

  assign in1_ready = in1_dest ? gnt2[0] : gnt1[0];
  assign in2_ready = in2_dest ? gnt2[1] : gnt1[1];

  // Stage 1: output slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_p1  <= 1'b0;
      data1_p1 <= '0;
      sel1_p1  <= PORT1;
    end else if (|gnt1) begin
      vld1_p1  <= 1'b1;
      data1_p1 <= gnt1[1] ? in2_data : in1_data;
      sel1_p1  <= gnt1[1] ? PORT2 : PORT1;
    end else if (out1_ready) begin
      vld1_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld2_p1  <= 1'b0;
      data2_p1 <= '0;
      sel2_p1  <= PORT1;
    end else if (|gnt2) begin
      vld2_p1  <= 1'b1;
      data2_p1 <= gnt2[1] ? in2_data : in1_data;
      sel2_p1  <= gnt2[1] ? PORT2 : PORT1;
    end else if (out2_ready) begin
      vld2_p1  <= 1'b0;
    end
  end

  // Each input targets one output, so at most one output sees contention
  // per cycle and the OR counts a cycle once.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (cont1 || cont2) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign out1_valid   = vld1_p1;
  assign out1_data    = data1_p1;
  assign sel1         = sel1_p1;
  assign out2_valid   = vld2_p1;
  assign out2_data    = data2_p1;
  assign sel2         = sel2_p1;
  assign conflict_cnt = cnt_p1;

endmodule
